instr_imm_encoder: RTL and testbench

//  Inverse of the immediate extender: packs a 32-bit immediate plus header fields into an
//  ARM-style 32-bit instruction and writes it into instruction memory through a streaming

---
 rtl/instr_imm_encoder_pkg.sv | 25 ++
 rtl/instr_imm_encoder_imm_field_pack.sv | 37 +++
 rtl/instr_imm_encoder.sv | 142 ++++++++++++++
 tb/tb_instr_imm_encoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_imm_encoder_pkg.sv
// Shared definitions for the instruction immediate encoder: ImmSrc codes,
// loader FSM state encoding and the field-width constants of the encoding.
package instr_imm_encoder_pkg;

  localparam logic [1:0] IMMSRC_NONE = 2'b00;
  localparam logic [1:0] IMMSRC_DP   = 2'b01;
  localparam logic [1:0] IMMSRC_MEM  = 2'b10;
  localparam logic [1:0] IMMSRC_BR   = 2'b11;

  localparam int HDR_W   = 8;
  localparam int MID_W   = 12;
  localparam int FIELD_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FULL = 2'b10
  } state_e;

  // True when every bit of a 7-bit slice carries the same value.
  function automatic logic all_equal7(input logic [6:0] v);
    return (v == 7'h00) || (v == 7'h7F);
  endfunction

endpackage

// File: rtl/instr_imm_encoder_imm_field_pack.sv
// Combinational packer: decides whether the extender can rebuild imm exactly
// from the instruction bits and produces Instr[23:0] (BR) or the low 12 bits
// of the immediate field (DP/MEM, upper bits zero).
module imm_field_pack
  import instr_imm_encoder_pkg::*;
(
  input  logic [1:0]         src_i,
  input  logic [31:0]        imm_i,
  output logic               fits_o,
  output logic [FIELD_W-1:0] field_o
);

  // Fit test and field selection per immediate source.
  always_comb begin
    fits_o  = 1'b0;
    field_o = '0;
    case (src_i)
      IMMSRC_DP: begin
        fits_o  = (imm_i[31:8] == {24{imm_i[7]}});
        field_o = {12'h000, 4'b0000, imm_i[7:0]};
      end
      IMMSRC_MEM: begin
        fits_o  = (imm_i[31:12] == {20{imm_i[11]}});
        field_o = {12'h000, imm_i[11:0]};
      end
      IMMSRC_BR: begin
        fits_o  = (imm_i[1:0] == 2'b00) && all_equal7(imm_i[31:25]);
        field_o = imm_i[25:2];
      end
      default: begin
        fits_o  = 1'b0;
        field_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_imm_encoder.sv
// Streaming instruction loader: accepts encode requests while in LOAD, writes
// encodings that the extender can reproduce, counts rejected requests.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready depends only on the FSM state, never on req_valid.
module instr_imm_encoder
  import instr_imm_encoder_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_src,
  input  logic [HDR_W-1:0]  req_hdr,
  input  logic [MID_W-1:0]  req_mid,
  input  logic [31:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              done,
  output state_e            state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;

  logic                accept;
  logic                fits;
  logic [FIELD_W-1:0]  field;
  logic [31:0]         enc;

  imm_field_pack u_pack (
    .src_i   (req_src),
    .imm_i   (req_imm),
    .fits_o  (fits),
    .field_o (field)
  );

  assign req_ready = (state_q == ST_LOAD);
  assign accept    = req_valid && req_ready;
  assign enc       = (req_src == IMMSRC_BR) ? {req_hdr, field}
                                            : {req_hdr, req_mid, field[11:0]};

  // Next-state, write pointer, error counters and write-port outputs.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;

    if (accept) begin
      if (fits) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
        mem_wdata_d = enc;
        word_cnt_d  = word_cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
          err_d      = 1'b0;
          err_cnt_d  = 8'd0;
        end
      end
      ST_LOAD: begin
        // finish wins over filling up; FULL is entered as the last write lands.
        if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (word_cnt_d == DEPTH_W) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Bench for instr_imm_encoder: directed vectors, a range-based reference model
// with a write scoreboard, a per-cycle compare process and literal checks.
module tb_instr_imm_encoder;
  import instr_imm_encoder_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int W      = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_src = 2'b00;
  logic [7:0]        req_hdr = 8'h00;
  logic [11:0]       req_mid = 12'h000;
  logic [31:0]       req_imm = 32'h0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_cnt;
  logic              err;
  logic [7:0]        err_cnt;
  logic              done;
  state_e            state_dbg;

  instr_imm_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_hdr(req_hdr), .req_mid(req_mid), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_cnt(word_cnt), .err(err), .err_cnt(err_cnt), .done(done),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // State as plain ints: 0 idle, 1 load, 2 full.
  int          m_state = 0;
  int          m_wc = 0;
  int          m_errcnt = 0;
  bit          m_err = 0;
  bit          m_we = 0;
  bit          m_done = 0;
  int          m_addr = 0;
  logic [31:0] m_wdata = 32'h0;
  bit          started = 0;
  logic [W-1:0] exp_q[$];

  function automatic bit model_fits(input logic [1:0] src, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (src)
      2'b01:   return (s >= -128) && (s <= 127);
      2'b10:   return (s >= -2048) && (s <= 2047);
      2'b11:   return ((imm % 4) == 0) && (s >= -(1 << 25)) && (s < (1 << 25));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_enc(input logic [1:0] src, input logic [7:0] hdr,
                                            input logic [11:0] mid, input logic [31:0] imm);
    logic [31:0] h, m;
    h = 32'(hdr) << 24;
    m = 32'(mid) << 12;
    case (src)
      2'b01:   return h | m | (imm & 32'hFF);
      2'b10:   return h | m | (imm & 32'hFFF);
      default: return h | ((imm >> 2) & 32'h00FF_FFFF);
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started  = 1;
      m_state  = 0; m_wc = 0; m_errcnt = 0; m_err = 0;
      m_we     = 0; m_done = 0; m_addr = 0; m_wdata = 32'h0;
      exp_q.delete();
    end else begin
      m_we   = 0;
      m_done = 0;
      if (m_state == 1 && req_valid) begin
        if (model_fits(req_src, req_imm)) begin
          m_we    = 1;
          m_addr  = m_wc;
          m_wdata = model_enc(req_src, req_hdr, req_mid, req_imm);
          exp_q.push_back({ADDR_W'(m_addr), m_wdata});
          m_wc++;
        end else begin
          m_err = 1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
      if (m_state == 0) begin
        if (start) begin
          m_state = 1; m_wc = 0; m_err = 0; m_errcnt = 0;
        end
      end else if (finish) begin
        m_state = 0;
        m_done  = 1;
      end else if (m_state == 1 && m_wc == DEPTH) begin
        m_state = 2;
      end
    end
  end

  // ---------------- compare process ----------------
  int wr_seen = 0;
  int done_seen = 0;
  int last_addr = -1;

  always @(negedge clk) begin
    if (started) begin
      state_e es;
      es = (m_state == 0) ? ST_IDLE : (m_state == 1) ? ST_LOAD : ST_FULL;
      chk("req_ready", 64'(req_ready), 64'(m_state == 1));
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      chk("word_cnt", 64'(word_cnt), 64'(m_wc));
      chk("err", 64'(err), 64'(m_err));
      chk("err_cnt", 64'(err_cnt), 64'(m_errcnt));
      chk("done", 64'(done), 64'(m_done));
      chk("state", 64'(state_dbg), 64'(es));
      if (mem_we === 1'b1) begin
        wr_seen++;
        last_addr = int'(mem_addr);
        if (exp_q.size() == 0) begin
          chk("write_unexpected", 64'({mem_addr, mem_wdata}), 64'(0));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("write_sb", 64'({mem_addr, mem_wdata}), 64'(e));
        end
      end
      if (done === 1'b1) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] src, input logic [7:0] hdr,
                      input logic [11:0] mid, input logic [31:0] imm);
    req_src = src; req_hdr = hdr; req_mid = mid; req_imm = imm;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int w0, d0;

  initial begin
    // 1: reset state, first DP write
    tick(3);
    chk("reset_we", 64'(mem_we), 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_wcnt", 64'(word_cnt), 64'(0));
    reset = 1'b0;
    tick();
    finish = 1'b1; tick(); finish = 1'b0;          // finish in IDLE: no done
    chk("idle_finish_done", 64'(done), 64'(0));
    req_valid = 1'b1; req_src = 2'b01; req_imm = 32'h1;
    pulse_start();                                  // request with start: not taken
    req_valid = 1'b0;
    chk("start_valid_nowrite", 64'(mem_we), 64'(0));
    send(2'b01, 8'hE2, 12'h812, 32'hFFFF_FF80);
    chk("t1_we", 64'(mem_we), 64'(1));
    chk("t1_addr", 64'(mem_addr), 64'(0));
    chk("t1_wdata", 64'(mem_wdata), 64'hE281_2080);
    chk("t1_wcnt", 64'(word_cnt), 64'(1));

    // 2: DP and MEM out of range
    send(2'b01, 8'hE2, 12'h812, 32'h0000_0100);
    chk("t2_we_a", 64'(mem_we), 64'(0));
    send(2'b10, 8'hE5, 12'h912, 32'h0000_0800);
    chk("t2_we_b", 64'(mem_we), 64'(0));
    chk("t2_err", 64'(err), 64'(1));
    chk("t2_errcnt", 64'(err_cnt), 64'(2));
    chk("t2_wcnt", 64'(word_cnt), 64'(1));
    chk("t2_hold_wdata", 64'(mem_wdata), 64'hE281_2080);

    // 3: branches
    send(2'b11, 8'hEA, 12'h000, 32'hFFFF_FFF8);
    chk("t3_wdata", 64'(mem_wdata), 64'hEAFF_FFFE);
    chk("t3_addr", 64'(mem_addr), 64'(1));
    send(2'b11, 8'hEA, 12'h000, 32'h0200_0000);
    chk("t3_big_we", 64'(mem_we), 64'(0));
    send(2'b11, 8'hEA, 12'h000, 32'h0000_0006);
    chk("t3_errcnt", 64'(err_cnt), 64'(4));
    send(2'b11, 8'h0A, 12'h000, 32'h01FF_FFFC);    // largest positive branch offset
    chk("t3_max_wdata", 64'(mem_wdata), 64'h0A7F_FFFF);

    // 4: MEM negative boundary, illegal src
    send(2'b10, 8'hE5, 12'h91F, 32'hFFFF_F800);
    chk("t4_low12", 64'(mem_wdata[11:0]), 64'h800);
    chk("t4_wdata", 64'(mem_wdata), 64'hE591_F800);
    send(2'b00, 8'hE5, 12'h91F, 32'h0);
    chk("t4_errcnt", 64'(err_cnt), 64'(5));
    chk("t4_wcnt", 64'(word_cnt), 64'(4));

    // 5: fill to DEPTH with back-to-back requests
    pulse_finish();
    pulse_start();
    chk("t5_err_cleared", 64'(err), 64'(0));
    chk("t5_wcnt_cleared", 64'(word_cnt), 64'(0));
    w0 = wr_seen;
    for (int i = 0; i < DEPTH + 3; i++) begin
      req_src = 2'(1 + (i % 3)); req_hdr = 8'($urandom_range(0, 255));
      req_mid = 12'($urandom_range(0, 4095));
      req_imm = (req_src == 2'b11) ? 32'(i * 4) : 32'(i);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("t5_writes", 64'(wr_seen - w0), 64'(DEPTH));
    chk("t5_last_addr", 64'(last_addr), 64'(DEPTH - 1));
    chk("t5_full", 64'(state_dbg), 64'(ST_FULL));
    chk("t5_ready", 64'(req_ready), 64'(0));
    chk("t5_wcnt", 64'(word_cnt), 64'(DEPTH));
    d0 = done_seen;
    pulse_finish();
    tick(3);
    chk("t5_done_once", 64'(done_seen - d0), 64'(1));
    pulse_start();
    chk("t5_restart_wcnt", 64'(word_cnt), 64'(0));
    chk("t5_restart_err", 64'(err), 64'(0));

    // 6: reset after an accept, then error saturation
    send(2'b00, 8'h00, 12'h000, 32'h0);
    send(2'b01, 8'hE3, 12'h0A0, 32'h0000_007F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_we", 64'(mem_we), 64'(0));
    chk("t6_wcnt", 64'(word_cnt), 64'(0));
    chk("t6_errcnt", 64'(err_cnt), 64'(0));
    chk("t6_state", 64'(state_dbg), 64'(ST_IDLE));
    pulse_start();
    req_valid = 1'b1; req_src = 2'b00;
    for (int i = 0; i < 300; i++) begin
      req_imm = 32'($urandom_range(0, 1000));
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("t6_sat", 64'(err_cnt), 64'(255));
    chk("t6_err", 64'(err), 64'(1));
    chk("t6_nowrites", 64'(word_cnt), 64'(0));
    tick(2);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
